uop_sequencer: RTL and testbench

Micro-operation sequencer that drives the 3-bit uOP index into the controller microcode ROM and consumes the ROM's RESET_uOP and READ_FLAGS strobes. It latches ALU ZERO/COUT into the registered flags the ROM uses for branch decisions. It also provides run, halt and single-instruction step control, an instruction counter, and a watchdog for microcode that never terminates. It sits between the front-panel/debug controls and the controller ROM.

---
 rtl/uop_sequencer.sv | 127 ++++++++++++
 tb/tb_uop_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uop_sequencer.sv
// Micro-operation sequencer between the front-panel run/step controls and the controller ROM.
// Optional build macro UOP_SEQ_MICROSTEP_EN makes each step advance a single uOP instead of a whole instruction.
module uop_sequencer #(
   parameter int ICOUNT_W = 16,
   parameter int MAX_UOP  = 6
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                RUN,
   input  logic                STEP,
   input  logic                RESET_uOP,
   input  logic                READ_FLAGS,
   input  logic                ZERO_IN,
   input  logic                COUT_IN,
   output logic [2:0]          uOP,
   output logic                ZERO_FLAG,
   output logic                COUT_FLAG,
   output logic                INSTR_DONE,
   output logic                HALTED,
   output logic                FAULT,
   output logic [ICOUNT_W-1:0] INSTR_COUNT
);

   localparam logic [2:0] UOP_FETCH  = 3'd0;
   localparam logic [2:0] UOP_DECODE = 3'd1;
   localparam logic [2:0] UOP_IDLE   = 3'd7;
   localparam logic [2:0] UOP_LAST   = 3'(MAX_UOP);

   typedef enum logic [1:0] {
      HALT,
      RUN_S,
      STEP_S
   } seq_state_t;

   seq_state_t state_q;
   seq_state_t state_d;
   logic       step_q;
   logic       step_rise;
   logic       adv;
   logic       retire;
   logic       wd_trip;
   logic [2:0] uop_d;

   // Next uOP: the idle slot always starts a fetch; fetch/decode cannot retire,
   // and running past the last legal slot trips the watchdog.
   always_comb begin
      adv       = (state_q == RUN_S) || (state_q == STEP_S);
      step_rise = STEP & ~step_q;
      retire    = 1'b0;
      wd_trip   = 1'b0;
      uop_d     = uOP;
      if (adv) begin
         if (uOP == UOP_IDLE) begin
            uop_d = UOP_FETCH;
         end else if (RESET_uOP && (uOP != UOP_FETCH) && (uOP != UOP_DECODE)) begin
            uop_d  = UOP_IDLE;
            retire = 1'b1;
         end else if (uOP >= UOP_LAST) begin
            uop_d   = UOP_IDLE;
            wd_trip = 1'b1;
         end else begin
            uop_d = uOP + 3'd1;
         end
      end
   end

   // Run control: halting only ever happens on the way into the idle slot,
   // so an instruction in flight always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HALT: begin
            if (RUN) begin
               state_d = RUN_S;
            end else if (step_rise) begin
               state_d = STEP_S;
            end
         end
         RUN_S: begin
            if (!RUN && (uop_d == UOP_IDLE)) begin
               state_d = HALT;
            end
         end
         STEP_S: begin
`ifdef UOP_SEQ_MICROSTEP_EN
            state_d = HALT;
`else
            if (uop_d == UOP_IDLE) begin
               state_d = HALT;
            end
`endif
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= HALT;
         step_q      <= 1'b0;
         uOP         <= UOP_IDLE;
         ZERO_FLAG   <= 1'b0;
         COUT_FLAG   <= 1'b0;
         INSTR_DONE  <= 1'b0;
         FAULT       <= 1'b0;
         INSTR_COUNT <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= STEP;
         uOP        <= uop_d;
         INSTR_DONE <= retire;
         if (wd_trip) begin
            FAULT <= 1'b1;
         end
         if (retire) begin
            INSTR_COUNT <= INSTR_COUNT + ICOUNT_W'(1);
         end
         if (adv && READ_FLAGS) begin
            ZERO_FLAG <= ZERO_IN;
            COUT_FLAG <= COUT_IN;
         end
      end
   end

   assign HALTED = (state_q == HALT);

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: one linear sequence of cycles, each with hand-computed expected outputs.
module tb_uop_sequencer;

   logic        CLK;
   logic        RESET;
   logic        RUN;
   logic        STEP;
   logic        RESET_uOP;
   logic        READ_FLAGS;
   logic        ZERO_IN;
   logic        COUT_IN;
   logic [2:0]  uOP;
   logic        ZERO_FLAG;
   logic        COUT_FLAG;
   logic        INSTR_DONE;
   logic        HALTED;
   logic        FAULT;
   logic [15:0] INSTR_COUNT;

   int checks   = 0;
   int failures = 0;

   uop_sequencer #(
      .ICOUNT_W (16),
      .MAX_UOP  (6)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .RUN         (RUN),
      .STEP        (STEP),
      .RESET_uOP   (RESET_uOP),
      .READ_FLAGS  (READ_FLAGS),
      .ZERO_IN     (ZERO_IN),
      .COUT_IN     (COUT_IN),
      .uOP         (uOP),
      .ZERO_FLAG   (ZERO_FLAG),
      .COUT_FLAG   (COUT_FLAG),
      .INSTR_DONE  (INSTR_DONE),
      .HALTED      (HALTED),
      .FAULT       (FAULT),
      .INSTR_COUNT (INSTR_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic applyStimulus(input logic rst, run, stp, ru, rf, zi, ci);
      RESET      = rst;
      RUN        = run;
      STEP       = stp;
      RESET_uOP  = ru;
      READ_FLAGS = rf;
      ZERO_IN    = zi;
      COUT_IN    = ci;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare just after the edge.
   task automatic cyc(input logic rst, run, stp, ru, rf, zi, ci,
                      input logic [2:0] e_uop, input logic e_done, e_halt, e_z, e_c,
                      input string tag);
      applyStimulus(rst, run, stp, ru, rf, zi, ci);
      @(posedge CLK);
      #1;
      checkOutput({tag, ".uop"},    32'(uOP),        32'(e_uop));
      checkOutput({tag, ".done"},   32'(INSTR_DONE), 32'(e_done));
      checkOutput({tag, ".halted"}, 32'(HALTED),     32'(e_halt));
      checkOutput({tag, ".zero"},   32'(ZERO_FLAG),  32'(e_z));
      checkOutput({tag, ".cout"},   32'(COUT_FLAG),  32'(e_c));
   endtask

   task automatic cnt(input logic [15:0] e_count, input logic e_fault, input string tag);
      checkOutput({tag, ".count"}, 32'(INSTR_COUNT), 32'(e_count));
      checkOutput({tag, ".fault"}, 32'(FAULT),       32'(e_fault));
   endtask

   initial begin
      applyStimulus(1, 1, 0, 0, 1, 1, 1);
      $display("[TB] reset with RUN and READ_FLAGS asserted");
      cyc(1, 1, 0, 0, 1, 1, 1, 3'd7, 0, 1, 0, 0, "rst1");
      cyc(1, 1, 0, 0, 1, 1, 1, 3'd7, 0, 1, 0, 0, "rst2");
      cnt(16'd0, 0, "rst");

      $display("[TB] free run, retire at uOP 3");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "run_enter");
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "run_u0");
         cyc(0, 1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "run_u1");
         cyc(0, 1, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "run_u2");
         cyc(0, 1, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, "run_u3");
         cyc(0, 1, 0, 1, 0, 0, 0, 3'd7, 1, 0, 0, 0, "run_ret");
      end
      cnt(16'd3, 0, "run");

      $display("[TB] flag capture and hold");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "flg_u0");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "flg_u1");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "flg_u2");
      cyc(0, 1, 0, 0, 1, 0, 1, 3'd3, 0, 0, 0, 1, "flg_rd1");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd4, 0, 0, 0, 1, "flg_u4");
      cyc(0, 1, 0, 0, 1, 1, 0, 3'd5, 0, 0, 1, 0, "flg_rd2");
      cyc(0, 1, 0, 1, 0, 0, 1, 3'd7, 1, 0, 1, 0, "flg_ret");
      cyc(0, 1, 0, 0, 0, 0, 1, 3'd0, 0, 0, 1, 0, "flg_hold0");
      cyc(0, 1, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1, 0, "flg_hold1");
      cyc(0, 1, 0, 0, 0, 0, 1, 3'd2, 0, 0, 1, 0, "flg_hold2");
      cyc(0, 1, 0, 1, 1, 0, 0, 3'd7, 1, 0, 0, 0, "flg_ret_rd");
      cnt(16'd5, 0, "flg");

      $display("[TB] drop RUN mid-instruction");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "hlt_u0");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "hlt_u1");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "hlt_drop");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, "hlt_u3");
      cyc(0, 0, 0, 1, 0, 0, 0, 3'd7, 1, 1, 0, 0, "hlt_ret");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "hlt_hold");
      cyc(0, 0, 0, 1, 1, 1, 1, 3'd7, 0, 1, 0, 0, "hlt_rf_ign");
      cnt(16'd6, 0, "hlt");

      $display("[TB] single-instruction step, STEP held high");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "stp_enter");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "stp_u0");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "stp_u1");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "stp_u2");
      cyc(0, 0, 1, 1, 0, 0, 0, 3'd7, 1, 1, 0, 0, "stp_ret");
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 1, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "stp_held");
      end
      cnt(16'd7, 0, "stp");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "stp_low");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "stp2_enter");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "stp2_u0");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "stp2_rise_ign");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "stp2_u2");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, "stp2_u3");
      cyc(0, 0, 1, 1, 0, 0, 0, 3'd7, 1, 1, 0, 0, "stp2_ret");
      cyc(0, 0, 1, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "stp2_nohold");
      cnt(16'd8, 0, "stp2");

      $display("[TB] RUN and STEP rise together");
      cyc(0, 0, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "pri_low");
      cyc(0, 1, 1, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "pri_both");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "pri_u0");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "pri_u1");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, "pri_u2");
      cyc(0, 1, 0, 1, 0, 0, 0, 3'd7, 1, 0, 0, 0, "pri_ret_run");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "pri_cont");
      cnt(16'd9, 0, "pri");

      $display("[TB] reset mid-instruction");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, "rstm_u1");
      cyc(1, 1, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "rstm");
      cnt(16'd0, 0, "rstm");

      $display("[TB] watchdog, RESET_uOP only during fetch/decode");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "wd_enter");
      cyc(0, 1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, "wd_u0");
      cyc(0, 1, 0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 0, "wd_u1_ign");
      cyc(0, 1, 0, 1, 0, 0, 0, 3'd2, 0, 0, 0, 0, "wd_u2_ign");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, "wd_u3");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd4, 0, 0, 0, 0, "wd_u4");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd5, 0, 0, 0, 0, "wd_u5");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd6, 0, 0, 0, 0, "wd_u6");
      cnt(16'd0, 0, "wd_pre");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0, 0, "wd_trip");
      cnt(16'd0, 1, "wd_trip");
      cyc(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "wd_cont");
      cnt(16'd0, 1, "wd_sticky");
      cyc(1, 1, 0, 0, 0, 0, 0, 3'd7, 0, 1, 0, 0, "wd_rst");
      cnt(16'd0, 0, "wd_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
